// File: rtl/instr_fetch.sv
// RV32I fetch stage: owns the PC, reads imem over req/gnt/rvalid,
// hands fetched words to decode over valid/ready.
module instr_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ,
    S_WAIT,
    S_VALID,
    S_HALT
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] fetch_pc, fetch_pc_n;
  logic [31:0] instr_n, instr_pc_n;
  logic        valid_n, mis_n;
  logic        drop, drop_n;

  logic redir_ok, redir_bad, redir_take, stale;

  always_comb begin
    redir_ok   = redirect_valid && (redirect_pc[1:0] == 2'b00);
    redir_bad  = redirect_valid && (redirect_pc[1:0] != 2'b00);
    redir_take = redir_ok ||
                 (redir_bad && (state inside {S_REQ, S_WAIT, S_VALID}));
    // a granted request whose response is still in flight
    stale      = (state == S_REQ && imem_gnt) ||
                 (state == S_WAIT && !imem_rvalid);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      pc             <= RESET_PC;
      fetch_pc       <= RESET_PC;
      drop           <= 1'b0;
      instr_valid    <= 1'b0;
      instr          <= NOP_INSTR;
      instr_pc       <= 32'h0;
      fetch_misalign <= 1'b0;
    end else begin
      state          <= state_n;
      pc             <= pc_n;
      fetch_pc       <= fetch_pc_n;
      drop           <= drop_n;
      instr_valid    <= valid_n;
      instr          <= instr_n;
      instr_pc       <= instr_pc_n;
      fetch_misalign <= mis_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      S_IDLE: state_n = S_REQ;
      S_REQ: begin
        if (redir_bad)     state_n = S_HALT;
        else if (imem_gnt) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (redir_bad)
          state_n = S_HALT;
        else if (imem_rvalid)
          state_n = (drop || redir_ok) ? S_REQ : S_VALID;
      end
      S_VALID: begin
        if (redir_bad)
          state_n = S_HALT;
        else if (redir_ok || instr_ready)
          state_n = S_REQ;
      end
      S_HALT: begin
        if (redir_ok) state_n = S_REQ;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_comb begin
    pc_n       = pc;
    fetch_pc_n = fetch_pc;
    drop_n     = drop;
    valid_n    = instr_valid;
    instr_n    = instr;
    instr_pc_n = instr_pc;
    mis_n      = fetch_misalign;

    if (state == S_REQ && imem_gnt)
      fetch_pc_n = pc;
    if (imem_rvalid && state != S_IDLE)
      drop_n = 1'b0;

    if (redir_take) begin
      valid_n = 1'b0;
      if (stale) drop_n = 1'b1;
      if (redir_bad) begin
        mis_n = 1'b1;
      end else begin
        mis_n = 1'b0;
        pc_n  = redirect_pc;
      end
    end else if (state == S_WAIT && imem_rvalid && !drop) begin
      instr_n    = imem_rdata;
      instr_pc_n = fetch_pc;
      valid_n    = 1'b1;
      pc_n       = fetch_pc + 32'd4;
    end else if (state == S_VALID && instr_ready) begin
      valid_n = 1'b0;
    end
  end

  always_comb begin
    imem_req  = (state == S_REQ);
    imem_addr = {pc[31:2], 2'b00};
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Bench for instr_fetch: directed scenarios, then random traffic
// against a fetch-stream model and a one-outstanding memory.
module tb_instr_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fetch_misalign;

  int checks = 0;
  int errors = 0;

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_gnt      (imem_gnt),
    .imem_rvalid   (imem_rvalid),
    .imem_rdata    (imem_rdata),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .instr         (instr),
    .instr_pc      (instr_pc),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .fetch_misalign(fetch_misalign)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return {a[7:0], a[31:8]} ^ 32'hC3A5_0F1E;
  endfunction

  logic [31:0] exp_next, oaddr, tgt, p_instr, p_pc;
  logic        exp_mis, outst, busy, redir, bad;
  logic        prev_valid, p_take;
  int          cnt, ndlv;

  initial begin
    rst = 1'b1;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = '0;

    repeat (2) @(negedge clk);
    chk("rst_req", imem_req, 0);
    chk("rst_valid", instr_valid, 0);
    chk("rst_instr", instr, NOP);
    chk("rst_ipc", instr_pc, 0);
    chk("rst_mis", fetch_misalign, 0);

    // basic fetch
    rst = 1'b0;
    @(negedge clk);
    chk("t1_req", imem_req, 1);
    chk("t1_addr", imem_addr, 32'h0);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("t1_wait_req", imem_req, 0);
    chk("t1_wait_valid", instr_valid, 0);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0050_0093;
    @(negedge clk);
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    chk("t1_valid", instr_valid, 1);
    chk("t1_instr", instr, 32'h0050_0093);
    chk("t1_ipc", instr_pc, 32'h0);

    // decode stall
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t2_valid", instr_valid, 1);
      chk("t2_instr", instr, 32'h0050_0093);
      chk("t2_ipc", instr_pc, 32'h0);
      chk("t2_noreq", imem_req, 0);
    end
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("t2_req", imem_req, 1);
    chk("t2_addr", imem_addr, 32'h4);

    // redirect while waiting drops the response
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc = 32'h100;
    @(negedge clk);
    redirect_valid = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    chk("t3_wait_req", imem_req, 0);
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t3_valid", instr_valid, 0);
    chk("t3_instr", instr, 32'h0050_0093);
    chk("t3_req", imem_req, 1);
    chk("t3_addr", imem_addr, 32'h100);

    // misaligned target halts until aligned redirect
    redirect_valid = 1'b1;
    redirect_pc = 32'h102;
    @(negedge clk);
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("t4_mis", fetch_misalign, 1);
      chk("t4_noreq", imem_req, 0);
      chk("t4_valid", instr_valid, 0);
      @(negedge clk);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h200;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t4_clr", fetch_misalign, 0);
    chk("t4_req", imem_req, 1);
    chk("t4_addr", imem_addr, 32'h200);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h00A0_0113;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t4_ipc", instr_pc, 32'h200);
    chk("t4_instr", instr, 32'h00A0_0113);

    // redirect from VALID to the top word, then wrap
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk);
    redirect_valid = 1'b0;
    chk("t5_valid", instr_valid, 0);
    chk("t5_addr", imem_addr, 32'hFFFF_FFFC);
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0010_0073;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t5_ipc", instr_pc, 32'hFFFF_FFFC);
    chk("t5_instr", instr, 32'h0010_0073);
    instr_ready = 1'b1;
    @(negedge clk);
    instr_ready = 1'b0;
    chk("t5_req", imem_req, 1);
    chk("t5_wrap", imem_addr, 32'h0);

    // reset mid-transaction
    imem_gnt = 1'b1;
    @(negedge clk);
    imem_gnt = 1'b0;
    chk("t6_wait", imem_req, 0);
    rst = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem_rvalid = 1'b0;
    chk("t6_req", imem_req, 0);
    chk("t6_valid", instr_valid, 0);
    chk("t6_instr", instr, NOP);
    chk("t6_ipc", instr_pc, 0);
    chk("t6_mis", fetch_misalign, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("t6_req1", imem_req, 1);
    chk("t6_addr", imem_addr, 32'h0);

    // random traffic
    exp_next = 32'h0;
    exp_mis = 1'b0;
    outst = 1'b0;
    oaddr = '0;
    cnt = 0;
    ndlv = 0;
    prev_valid = 1'b0;
    p_take = 1'b0;
    p_instr = '0;
    p_pc = '0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      busy = outst;

      chk("mis", fetch_misalign, exp_mis);
      if (exp_mis) begin
        chk("halt_req", imem_req, 0);
        chk("halt_valid", instr_valid, 0);
      end
      if (prev_valid && p_take) begin
        chk("consume", instr_valid, 0);
      end else if (prev_valid) begin
        chk("hold_valid", instr_valid, 1);
        chk("hold_instr", instr, p_instr);
        chk("hold_pc", instr_pc, p_pc);
      end else if (instr_valid) begin
        chk("dlv_pc", instr_pc, exp_next);
        chk("dlv_instr", instr, word_of(exp_next));
        exp_next = exp_next + 32'd4;
        ndlv++;
      end

      imem_rvalid = 1'b0;
      imem_rdata = $urandom;
      if (outst) begin
        if (cnt == 0) begin
          imem_rvalid = 1'b1;
          imem_rdata = word_of(oaddr);
          outst = 1'b0;
        end else begin
          cnt--;
        end
      end

      redir = ($urandom_range(0, 11) == 0);
      bad = redir && ($urandom_range(0, 5) == 0);
      if (bad) begin
        tgt = $urandom;
        if (tgt[1:0] == 2'b00) tgt[0] = 1'b1;
      end else if ($urandom_range(0, 3) == 0) begin
        tgt = 32'hFFFF_FFF0 + 4 * $urandom_range(0, 3);
      end else begin
        tgt = 4 * $urandom_range(0, 63);
      end
      redirect_valid = redir;
      redirect_pc = redir ? tgt : $urandom;

      imem_gnt = 1'b0;
      if (imem_req && !busy && $urandom_range(0, 1) == 1) begin
        imem_gnt = 1'b1;
        oaddr = imem_addr;
        outst = 1'b1;
        cnt = $urandom_range(0, 2);
        if (!redir) chk("gnt_addr", imem_addr, exp_next);
      end

      if (redir) begin
        if (bad) begin
          exp_mis = 1'b1;
        end else begin
          exp_mis = 1'b0;
          exp_next = tgt;
        end
      end

      instr_ready = ($urandom_range(0, 2) != 0);
      p_take = instr_ready || redir;
      prev_valid = instr_valid;
      p_instr = instr;
      p_pc = instr_pc;
    end

    chk("progress", 32'(ndlv >= 50), 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
